pipeline_controller: RTL and testbench
======================================

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of cycles squashed after a taken branch (legal 1..3).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of each saturating statistics counter.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port dec_valid  in  1  decode stage holds a valid instruction.
REQ-006 SHALL have ports dec_src_a / dec_src_b  in  3 each  decode source register numbers.
REQ-007 SHALL have ports dec_use_a / dec_use_b  in  1 each  the source is read as a register (not a constant).
REQ-008 SHALL have port stg_wr  in  3  per stage [0]=execute [1]=memory [2]=writeback: the instruction writes a register.
REQ-009 SHALL have port stg_ld  in  3  per stage: the written value comes from memory access.
REQ-010 SHALL have port stg_dst  in  3x3  per-stage destination register numbers.
REQ-011 SHALL have port br_taken  in  1  execute stage resolved a taken branch this cycle.
REQ-012 SHALL have port stall_o  out  8  stall vector for the pipeline register block: [0] load-use, [1] branch flush, [7:2] zero.
REQ-013 SHALL have port hold_pc  out  1  fetch PC and fetch register hold.
REQ-014 SHALL have port flush_o  out  1  fetch/decode contents squashed.
REQ-015 SHALL have ports fwd_a / fwd_b  out  2 each  operand source: 00 register file, 01 execute result, 10 memory-stage result, 11 writeback value.
REQ-016 SHALL have ports stall_cnt / flush_cnt  out  CNT_W each  cycles with stall_o[0] / stall_o[1] set.

Function
REQ-017 SHALL implement FSM states RUN and FLUSH, with down-counter fl_cnt (2 bits).
REQ-018 RUN->FLUSH SHALL occur on br_taken=1, loading fl_cnt=FLUSH_CYCLES-1.
REQ-019 In FLUSH, fl_cnt SHALL decrement each cycle; FLUSH->RUN SHALL occur when fl_cnt=0.
REQ-020 br_taken=1 while in FLUSH SHALL reload fl_cnt=FLUSH_CYCLES-1 and remain in FLUSH.
REQ-021 stall_o[1] and flush_o SHALL be 1 exactly when state=FLUSH (registered), giving FLUSH_CYCLES cycles per taken branch, starting the cycle after br_taken.
REQ-022 Load-use hazard (combinational) SHALL be dec_valid & stg_wr[0] & stg_ld[0] & ((dec_use_a & stg_dst[0]==dec_src_a) | (dec_use_b & stg_dst[0]==dec_src_b)).
REQ-023 stall_o[0] and hold_pc SHALL equal the load-use hazard, gated to 0 when state=FLUSH or br_taken=1 (flush wins).
REQ-024 fwd_x SHALL be 00 when dec_use_x=0; otherwise nearest-stage match first: 01 if stg_wr[0] & ~stg_ld[0] & dst match, else 10 if stg_wr[1] & match, else 11 if stg_wr[2] & match, else 00.
REQ-025 A stage-0 load match SHALL yield fwd_x=00 (the stall covers it); forwarding SHALL re-evaluate next cycle, when the load is in stage 1 (result 10).
REQ-026 fwd_a/fwd_b SHALL be purely combinational and independent of FSM state.
REQ-027 stall_cnt SHALL increment each cycle stall_o[0]=1; flush_cnt SHALL increment each cycle stall_o[1]=1; both SHALL saturate at all-ones.
REQ-028 A load-use stall SHALL last exactly one cycle per hazard, because the bubble inserted by the pipeline registers clears stg_wr[0] next cycle; no internal stall state SHALL exist.

Reset
REQ-029 With rst=1 at a rising edge: state=RUN, fl_cnt=0, stall_cnt=0, flush_cnt=0.
REQ-030 After reset, stall_o[1]=0 and flush_o=0; stall_o[0], hold_pc and fwd_* follow inputs combinationally.
REQ-031 rst SHALL override br_taken in the same cycle; rst during FLUSH SHALL abort it, with flush_o=0 the next cycle.

Verification
REQ-032 stg_wr[0]=1, stg_ld[0]=1, stg_dst[0]=3, dec_valid=1, dec_use_a=1, dec_src_a=3 -> stall_o=8'h01, hold_pc=1, fwd_a=00; next cycle (stg_wr[0]=0, stage 1 holds dst 3) -> stall_o=0, fwd_a=10, stall_cnt=1.
REQ-033 br_taken pulse one cycle, FLUSH_CYCLES=2 -> stall_o=8'h02 and flush_o=1 for the next 2 cycles, then 0; flush_cnt=2.
REQ-034 br_taken and a load-use hazard in the same cycle -> stall_o[0]=0; following cycles stall_o=8'h02.
REQ-035 dst=5 writing in all of stages 0/1/2 (non-load), dec_src_b=5, dec_use_b=1 -> fwd_b=01; stage 0 cleared -> 10; only stage 2 -> 11; dec_use_b=0 -> 00.
REQ-036 rst asserted on the second flush cycle -> flush_o=0 next cycle, counters=0; stall_cnt preloaded to all-ones plus a hazard -> stall_cnt stays all-ones.

Source files
------------

// File: rtl/pipeline_controller.sv
// Pipeline hazard controller: detects load-use hazards on the decode
// operands, selects forwarding sources, squashes fetch/decode for a fixed
// number of cycles after a taken branch and keeps saturating statistics.
module pipeline_controller #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [2:0]       dec_src_a,
    input  logic [2:0]       dec_src_b,
    input  logic             dec_use_a,
    input  logic             dec_use_b,
    input  logic [2:0]       stg_wr,
    input  logic [2:0]       stg_ld,
    input  logic [8:0]       stg_dst,
    input  logic             br_taken,
    output logic [7:0]       stall_o,
    output logic             hold_pc,
    output logic             flush_o,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Reload value of the flush down-counter; reaching zero ends the flush.
    localparam logic [1:0] FL_LOAD = 2'(FLUSH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       fl_cnt_q, fl_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             load_use;
    logic             in_flush;

    // Operands packed as {b, a} so both share one forwarding mux body.
    logic [1:0]       op_use;
    logic [5:0]       op_src;
    logic [3:0]       op_fwd;

    assign op_use = {dec_use_b, dec_use_a};
    assign op_src = {dec_src_b, dec_src_a};

    assign in_flush = (state_q == FLUSH);

    // Load in execute whose destination is read by the decoded instruction.
    always_comb begin
        load_use = dec_valid & stg_wr[0] & stg_ld[0] &
                   ((dec_use_a & (stg_dst[2:0] == dec_src_a)) |
                    (dec_use_b & (stg_dst[2:0] == dec_src_b)));
    end

    // Nearest-stage forwarding per operand; an execute-stage load is not
    // forwardable (its value does not exist yet), so it falls through.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                op_fwd[2*gi +: 2] = 2'b00;
                if (op_use[gi]) begin
                    if (stg_wr[0] & ~stg_ld[0] & (stg_dst[2:0] == op_src[3*gi +: 3]))
                        op_fwd[2*gi +: 2] = 2'b01;
                    else if (stg_wr[1] & (stg_dst[5:3] == op_src[3*gi +: 3]))
                        op_fwd[2*gi +: 2] = 2'b10;
                    else if (stg_wr[2] & (stg_dst[8:6] == op_src[3*gi +: 3]))
                        op_fwd[2*gi +: 2] = 2'b11;
                end
            end
        end
    endgenerate

    assign fwd_a = op_fwd[1:0];
    assign fwd_b = op_fwd[3:2];

    // Flush wins over a load-use stall: the stalled instruction is squashed anyway.
    always_comb begin
        stall_o    = 8'h00;
        stall_o[0] = load_use & ~in_flush & ~br_taken;
        stall_o[1] = in_flush;
        hold_pc    = stall_o[0];
        flush_o    = in_flush;
    end

    // Next-state logic for the branch flush FSM and statistics counters.
    always_comb begin
        state_d     = state_q;
        fl_cnt_d    = fl_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (br_taken) begin
            state_d  = FLUSH;
            fl_cnt_d = FL_LOAD;
        end else if (state_q == FLUSH) begin
            if (fl_cnt_q == 2'd0) begin
                state_d = RUN;
            end else begin
                fl_cnt_d = fl_cnt_q - 2'd1;
            end
        end
        if (stall_o[0] && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (stall_o[1] && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // State register with synchronous reset overriding any branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            fl_cnt_q    <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fl_cnt_q    <= fl_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: directed scenarios followed by
// random stimulus, all compared against a cycle-level behavioural model.
module tb_pipeline_controller;

    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 3;   // small so saturation is reachable

    logic             clk = 1'b0;
    logic             rst;
    logic             dec_valid;
    logic [2:0]       dec_src_a, dec_src_b;
    logic             dec_use_a, dec_use_b;
    logic [2:0]       stg_wr, stg_ld;
    logic [8:0]       stg_dst;
    logic             br_taken;
    logic [7:0]       stall_o;
    logic             hold_pc, flush_o;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    // Model state: remaining flush cycles and counter values.
    int m_flush_rem = 0;
    int m_stall_cnt = 0;
    int m_flush_cnt = 0;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    pipeline_controller #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_src_a(dec_src_a), .dec_src_b(dec_src_b),
        .dec_use_a(dec_use_a), .dec_use_b(dec_use_b),
        .stg_wr(stg_wr), .stg_ld(stg_ld), .stg_dst(stg_dst),
        .br_taken(br_taken), .stall_o(stall_o), .hold_pc(hold_pc),
        .flush_o(flush_o), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] dst_of(input int s);
        return stg_dst[3*s +: 3];
    endfunction

    // Nearest writing stage whose value exists; an execute-stage load has none yet.
    function automatic logic [1:0] m_fwd(input logic use_r, input logic [2:0] src);
        if (!use_r) return 2'b00;
        for (int s = 0; s < 3; s++) begin
            if (stg_wr[s] && dst_of(s) == src && !(s == 0 && stg_ld[0]))
                return 2'(s + 1);
        end
        return 2'b00;
    endfunction

    function automatic bit m_hazard();
        if (!(dec_valid && stg_wr[0] && stg_ld[0])) return 1'b0;
        return (dec_use_a && dst_of(0) == dec_src_a) || (dec_use_b && dst_of(0) == dec_src_b);
    endfunction

    // One clock cycle: check combinational outputs, clock, advance model, check state.
    task automatic tick(input string tag);
        bit flushing, stall;
        #1;
        flushing = (m_flush_rem > 0);
        stall    = m_hazard() && !flushing && !br_taken;
        chk({tag, "_stall"}, 32'(stall_o), {30'd0, flushing, stall});
        chk({tag, "_hold"},  32'(hold_pc), 32'(stall));
        chk({tag, "_flush"}, 32'(flush_o), 32'(flushing));
        chk({tag, "_fwda"},  32'(fwd_a),   32'(m_fwd(dec_use_a, dec_src_a)));
        chk({tag, "_fwdb"},  32'(fwd_b),   32'(m_fwd(dec_use_b, dec_src_b)));
        @(posedge clk);
        if (rst) begin
            m_flush_rem = 0;
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
            if (stall && m_stall_cnt < CNT_MAX) m_stall_cnt++;
            if (flushing && m_flush_cnt < CNT_MAX) m_flush_cnt++;
            if (br_taken) m_flush_rem = FLUSH_CYCLES;
            else if (m_flush_rem > 0) m_flush_rem--;
        end
        #1;
        chk({tag, "_scnt"}, 32'(stall_cnt), 32'(m_stall_cnt));
        chk({tag, "_fcnt"}, 32'(flush_cnt), 32'(m_flush_cnt));
    endtask

    task automatic idle_inputs();
        rst = 0; dec_valid = 0; dec_src_a = 0; dec_src_b = 0;
        dec_use_a = 0; dec_use_b = 0; stg_wr = 0; stg_ld = 0;
        stg_dst = 0; br_taken = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        @(posedge clk);
        #1;
        tick("reset");
        rst = 0;
        tick("post_reset");
        chk("reset_flush", 32'(flush_o), 32'd0);
        chk("reset_scnt",  32'(stall_cnt), 32'd0);

        // Load-use on operand A, then the load moves to memory stage.
        stg_wr = 3'b001; stg_ld = 3'b001; stg_dst = {3'd0, 3'd0, 3'd3};
        dec_valid = 1; dec_use_a = 1; dec_src_a = 3;
        #1;
        chk("lu_stall_o", 32'(stall_o), 32'h01);
        chk("lu_hold",    32'(hold_pc), 32'd1);
        chk("lu_fwda",    32'(fwd_a),   32'd0);
        tick("lu");
        stg_wr = 3'b010; stg_ld = 3'b010; stg_dst = {3'd0, 3'd3, 3'd0};
        #1;
        chk("lu2_stall_o", 32'(stall_o), 32'h00);
        chk("lu2_fwda",    32'(fwd_a),   32'd2);
        chk("lu2_scnt",    32'(stall_cnt), 32'd1);
        tick("lu2");

        // Single taken branch: two flush cycles.
        idle_inputs();
        br_taken = 1;
        tick("br");
        br_taken = 0;
        #1 chk("br_c1", 32'(stall_o), 32'h02);
        tick("br_c1");
        #1 chk("br_c2", 32'(flush_o), 32'd1);
        tick("br_c2");
        #1 chk("br_end", 32'(stall_o), 32'h00);
        chk("br_fcnt", 32'(flush_cnt), 32'd2);
        tick("br_end");

        // Branch and hazard together: flush wins.
        stg_wr = 3'b001; stg_ld = 3'b001; stg_dst = {3'd0, 3'd0, 3'd6};
        dec_valid = 1; dec_use_b = 1; dec_src_b = 6; br_taken = 1;
        #1 chk("brlu_stall0", 32'(stall_o), 32'h00);
        tick("brlu");
        br_taken = 0;
        #1 chk("brlu_c1", 32'(stall_o), 32'h02);
        tick("brlu_c1");
        tick("brlu_c2");

        // Forwarding priority on operand B.
        idle_inputs();
        dec_valid = 1; dec_use_b = 1; dec_src_b = 5;
        stg_wr = 3'b111; stg_dst = {3'd5, 3'd5, 3'd5};
        #1 chk("fwd_ex", 32'(fwd_b), 32'd1);
        tick("fwd_ex");
        stg_wr = 3'b110;
        #1 chk("fwd_mem", 32'(fwd_b), 32'd2);
        tick("fwd_mem");
        stg_wr = 3'b100;
        #1 chk("fwd_wb", 32'(fwd_b), 32'd3);
        tick("fwd_wb");
        dec_use_b = 0;
        #1 chk("fwd_none", 32'(fwd_b), 32'd0);
        tick("fwd_none");

        // Reset in the middle of a flush aborts it.
        idle_inputs();
        br_taken = 1;
        tick("rf_br");
        br_taken = 0;
        tick("rf_c1");
        rst = 1;
        tick("rf_c2");
        rst = 0;
        #1 chk("rf_flush", 32'(flush_o), 32'd0);
        chk("rf_fcnt", 32'(flush_cnt), 32'd0);
        tick("rf_after");

        // Saturation of the stall counter.
        stg_wr = 3'b001; stg_ld = 3'b001; stg_dst = 9'd2;
        dec_valid = 1; dec_use_a = 1; dec_src_a = 2;
        for (int i = 0; i < CNT_MAX + 3; i++) tick("sat");
        #1 chk("sat_scnt", 32'(stall_cnt), 32'(CNT_MAX));
        idle_inputs();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 59) == 0);
            br_taken  = ($urandom_range(0, 5) == 0);
            dec_valid = 1'($urandom);
            dec_use_a = 1'($urandom);
            dec_use_b = 1'($urandom);
            dec_src_a = 3'($urandom_range(0, 3));
            dec_src_b = 3'($urandom_range(0, 3));
            stg_wr    = 3'($urandom);
            stg_ld    = 3'($urandom);
            stg_dst   = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))};
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
